// File: rtl/idu_preg_alloc_pkg.sv
// Shared IDU package for the physical-register allocator.
// Holds the preg index width, the free-list depth, and the pointer types
// used by both the free-list FIFO and the allocation control.
package idu_preg_alloc_pkg;

  localparam int PREG_NUM       = 64;
  localparam int FREELIST_DEPTH = 32;
  localparam int PREG_W         = $clog2(PREG_NUM);
  localparam int IDX_W          = $clog2(FREELIST_DEPTH);
  localparam int PTR_W          = IDX_W + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  ptr_t;

endpackage

// File: rtl/idu_preg_freelist_fifo.sv
// Circular free list of physical register indices.
// A speculative head is popped at decode, a commit head follows retirement,
// and the tail receives freed pregs. A flush rewinds the speculative head
// onto the commit head so every uncommitted allocation returns to the list.
// Ports:
//   clk, rst_clk     core clock, asynchronous active-low reset
//   pop              consume entry[head]
//   push, push_data  append a freed preg at entry[tail]
//   commit_adv       one retiring instruction had allocated a preg
//   flush            rewind head to the updated commit head (no pop)
//   head_data        preg currently at the head
//   empty            no free preg available
//   count            tail - head (0..32)
module idu_preg_freelist_fifo
  import idu_preg_alloc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              pop,
  input  logic              push,
  input  logic [PREG_W-1:0] push_data,
  input  logic              commit_adv,
  input  logic              flush,
  output logic [PREG_W-1:0] head_data,
  output logic              empty,
  output logic [PTR_W-1:0]  count
);

  ptr_t  head;
  ptr_t  commit_head;
  ptr_t  tail;
  ptr_t  commit_next;
  preg_t entry [FREELIST_DEPTH];
  logic  full;

  // Flush uses the commit head as it stands after this cycle's retirement.
  assign commit_next = commit_head + ptr_t'(commit_adv);

  assign head_data = entry[head[IDX_W-1:0]];
  assign empty     = (head == tail);
  assign full      = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign count     = tail - head;

  // Out of reset the list holds pregs 32..63; the low 32 are architectural.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= ptr_t'(FREELIST_DEPTH);
      for (int i = 0; i < FREELIST_DEPTH; i++) begin
        entry[i] <= preg_t'(FREELIST_DEPTH + i);
      end
    end else begin
      commit_head <= commit_next;
      if (flush) begin
        head <= commit_next;
      end else if (pop) begin
        head <= head + ptr_t'(1);
      end
      if (push) begin
        entry[tail[IDX_W-1:0]] <= push_data;
        tail                   <= tail + ptr_t'(1);
      end
    end
  end

  // A push into a full list is only safe when the head slot is vacated
  // in the same cycle.
  a_push_when_full : assert property (@(posedge clk) disable iff (!rst_clk)
    !(push && full && !pop));

  // Retirement can never commit an allocation that was never handed out.
  a_commit_past_head : assert property (@(posedge clk) disable iff (!rst_clk)
    !(commit_adv && (commit_head == head)));

endmodule

// File: rtl/idu_preg_alloc.sv
// Decode-stage physical register allocator.
// Grants the preg at the head of the free list combinationally, pops only
// when decode actually advances, recycles released pregs from retirement,
// and rewinds speculative allocations on a global flush.
// Optional feature macro: KS_PREG_FREE_BYPASS_EN -- when defined, an empty
// list hands a same-cycle released preg straight to decode.
// Ports:
//   clk, rst_clk          core clock, asynchronous active-low reset
//   rtu_global_flush      pipeline flush from retire
//   preg_req, idu_id_adv  decode needs a preg / decode advances
//   rtu_retire_*          retirement commit and release of an old preg
//   preg_grant_vld        grant valid, preg_grant carries the index
//   preg_stall            decode must stall, nothing to grant
//   free_cnt              number of free pregs
module idu_preg_alloc
  import idu_preg_alloc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,
  input  logic              preg_req,
  input  logic              idu_id_adv,
  input  logic              rtu_retire_vld,
  input  logic              rtu_retire_alloc,
  input  logic              rtu_retire_rel_vld,
  input  logic [PREG_W-1:0] rtu_retire_rel_preg,
  output logic              preg_grant_vld,
  output logic [PREG_W-1:0] preg_grant,
  output logic              preg_stall,
  output logic [PREG_W-1:0] free_cnt
);

  logic        empty;
  logic        release_vld;
  logic        commit_adv;
  logic        bypass;
  logic        pop;
  logic        push;
  preg_t       head_data;
  ptr_t        count;

  assign release_vld = rtu_retire_vld & rtu_retire_rel_vld;
  assign commit_adv  = rtu_retire_vld & rtu_retire_alloc;

`ifdef KS_PREG_FREE_BYPASS_EN
  assign bypass = empty & release_vld & preg_req & ~rtu_global_flush;
`else
  assign bypass = 1'b0;
`endif

  // Outputs are qualified by reset so in-flight grants vanish the moment
  // reset asserts, without waiting for a clock edge.
  assign preg_grant_vld = rst_clk & preg_req & ~rtu_global_flush & (~empty | bypass);
  assign preg_stall     = rst_clk & preg_req & ~rtu_global_flush & empty & ~bypass;
  assign preg_grant     = bypass ? rtu_retire_rel_preg : head_data;

  // A grant held across a decode stall is the same allocation, so only
  // the advancing cycle pops. A bypassed preg consumed by decode never
  // enters the list at all.
  assign pop  = preg_grant_vld & idu_id_adv & ~bypass;
  assign push = release_vld & ~(bypass & idu_id_adv);

  assign free_cnt = count;

  idu_preg_freelist_fifo u_fifo (
    .clk        (clk),
    .rst_clk    (rst_clk),
    .pop        (pop),
    .push       (push),
    .push_data  (rtu_retire_rel_preg),
    .commit_adv (commit_adv),
    .flush      (rtu_global_flush),
    .head_data  (head_data),
    .empty      (empty),
    .count      (count)
  );

endmodule

// File: tb/tb_idu_preg_alloc.sv
// Self-checking bench for idu_preg_alloc.
// A queue-level model holds the free pregs in grant order plus the pregs
// handed out but not yet committed; outputs are compared every cycle and a
// set of directed sequences pins the model with literal expectations.
module tb_idu_preg_alloc;

  logic       clk = 1'b0;
  logic       rst_clk = 1'b0;
  logic       rtu_global_flush = 1'b0;
  logic       preg_req = 1'b0;
  logic       idu_id_adv = 1'b0;
  logic       rtu_retire_vld = 1'b0;
  logic       rtu_retire_alloc = 1'b0;
  logic       rtu_retire_rel_vld = 1'b0;
  logic [5:0] rtu_retire_rel_preg = '0;
  logic       preg_grant_vld;
  logic [5:0] preg_grant;
  logic       preg_stall;
  logic [5:0] free_cnt;

  int checks = 0;
  int failures = 0;

  logic [5:0] free_q[$];
  logic [5:0] spec_q[$];

  idu_preg_alloc dut (
    .clk                 (clk),
    .rst_clk             (rst_clk),
    .rtu_global_flush    (rtu_global_flush),
    .preg_req            (preg_req),
    .idu_id_adv          (idu_id_adv),
    .rtu_retire_vld      (rtu_retire_vld),
    .rtu_retire_alloc    (rtu_retire_alloc),
    .rtu_retire_rel_vld  (rtu_retire_rel_vld),
    .rtu_retire_rel_preg (rtu_retire_rel_preg),
    .preg_grant_vld      (preg_grant_vld),
    .preg_grant          (preg_grant),
    .preg_stall          (preg_stall),
    .free_cnt            (free_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    free_q.delete();
    spec_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(6'(32 + i));
  endtask

  function automatic bit modelBypass();
`ifdef KS_PREG_FREE_BYPASS_EN
    return (free_q.size() == 0) && rtu_retire_vld && rtu_retire_rel_vld &&
           preg_req && !rtu_global_flush;
`else
    return 1'b0;
`endif
  endfunction

  // Model state advances on the same edge as the DUT, from the inputs
  // that were stable across the cycle.
  always @(posedge clk) begin
    bit byp;
    bit granted;
    if (!rst_clk) begin
      modelReset();
    end else begin
      byp     = modelBypass();
      granted = preg_req && !rtu_global_flush && (free_q.size() != 0 || byp);
      if (rtu_retire_vld && rtu_retire_alloc && spec_q.size() != 0)
        void'(spec_q.pop_front());
      if (rtu_global_flush) begin
        free_q = {spec_q, free_q};
        spec_q.delete();
      end else if (granted && idu_id_adv && !byp) begin
        spec_q.push_back(free_q.pop_front());
      end
      if (rtu_retire_vld && rtu_retire_rel_vld && !(byp && idu_id_adv))
        free_q.push_back(rtu_retire_rel_preg);
    end
  end

  // Every cycle, mid-cycle, the DUT outputs must match the model.
  always @(negedge clk) begin
    bit byp;
    bit exp_vld;
    bit exp_stall;
    if (!rst_clk) begin
      checkValue("cmp_rst_vld", 8'(preg_grant_vld), 8'd0);
      checkValue("cmp_rst_stall", 8'(preg_stall), 8'd0);
      checkValue("cmp_rst_cnt", 8'(free_cnt), 8'd32);
    end else begin
      byp       = modelBypass();
      exp_vld   = preg_req && !rtu_global_flush && (free_q.size() != 0 || byp);
      exp_stall = preg_req && !rtu_global_flush && (free_q.size() == 0) && !byp;
      checkValue("cmp_vld", 8'(preg_grant_vld), 8'(exp_vld));
      checkValue("cmp_stall", 8'(preg_stall), 8'(exp_stall));
      checkValue("cmp_cnt", 8'(free_cnt), 8'(free_q.size()));
      if (exp_vld)
        checkValue("cmp_grant", 8'(preg_grant), byp ? 8'(rtu_retire_rel_preg) : 8'(free_q[0]));
    end
  end

  task automatic driveInputs(input bit req, input bit adv, input bit rv, input bit ra,
                             input bit rrv, input logic [5:0] rp, input bit fl);
    preg_req            = req;
    idu_id_adv          = adv;
    rtu_retire_vld      = rv;
    rtu_retire_alloc    = ra;
    rtu_retire_rel_vld  = rrv;
    rtu_retire_rel_preg = rp;
    rtu_global_flush    = fl;
  endtask

  task automatic applyStimulus(input bit req, input bit adv, input bit rv, input bit ra,
                               input bit rrv, input logic [5:0] rp, input bit fl);
    @(posedge clk);
    #1;
    driveInputs(req, adv, rv, ra, rrv, rp, fl);
  endtask

  task automatic checkOutput(input string name, input bit vld, input logic [5:0] grant,
                             input bit stall, input logic [5:0] cnt);
    @(negedge clk);
    #1;
    checkValue({name, "_vld"}, 8'(preg_grant_vld), 8'(vld));
    checkValue({name, "_stall"}, 8'(preg_stall), 8'(stall));
    checkValue({name, "_cnt"}, 8'(free_cnt), 8'(cnt));
    if (vld) checkValue({name, "_grant"}, 8'(preg_grant), 8'(grant));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_clk = 1'b0;
    driveInputs(1, 1, 0, 0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0, 32);
    @(posedge clk);
    @(posedge clk);
    #1;
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    rst_clk = 1'b1;
  endtask

  task automatic randomCycle();
    bit ra;
    bit rrv;
    bit rv;
    bit fl;
    @(posedge clk);
    #1;
    ra  = (spec_q.size() != 0) && ($urandom_range(0, 2) == 0);
    rrv = (spec_q.size() + free_q.size() < 32) && ($urandom_range(0, 2) == 0);
    rv  = ra || rrv || ($urandom_range(0, 7) == 0);
    fl  = ($urandom_range(0, 19) == 0);
    driveInputs($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rv, ra, rrv,
                6'($urandom_range(0, 63)), fl);
  endtask

  initial begin
    modelReset();
    doReset();

    // Straight allocation from reset.
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("alloc0", 1, 32, 0, 32);
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("alloc1", 1, 33, 0, 31);
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("alloc2", 1, 34, 0, 30);
    applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("alloc_end", 0, 0, 0, 29);

    // Grant held across a decode stall pops exactly once.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0); checkOutput("hold", 1, 32, 0, 32);
    end
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("hold_go", 1, 32, 0, 32);
    applyStimulus(1, 0, 0, 0, 0, 0, 0); checkOutput("hold_next", 1, 33, 0, 31);

    // Drain, stall, then recover through a release.
    doReset();
    for (int i = 0; i < 32; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("drained", 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 1, 5, 0);
`ifdef KS_PREG_FREE_BYPASS_EN
    checkOutput("bypass", 1, 5, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("bypass_after", 0, 0, 1, 0);
`else
    checkOutput("release_stall", 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("release_grant", 1, 5, 0, 1);
`endif

    // Flush rewinds onto the commit head.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0); checkOutput("retire", 0, 0, 0, 28);
    applyStimulus(1, 1, 0, 0, 0, 0, 1); checkOutput("flush", 0, 0, 0, 28);
    applyStimulus(1, 0, 0, 0, 0, 0, 0); checkOutput("after_flush", 1, 33, 0, 31);

    // Pop and push on a full list; the pushed preg lands in slot 0.
    doReset();
    applyStimulus(1, 1, 1, 0, 1, 7, 0); checkOutput("full_swap", 1, 32, 0, 32);
    applyStimulus(1, 1, 0, 0, 0, 0, 0); checkOutput("full_swap_next", 1, 33, 0, 32);
    for (int i = 0; i < 30; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0); checkOutput("wrap", 1, 7, 0, 1);

    // Randomized traffic with an asynchronous reset in the middle.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      randomCycle();
      if (n == 1500) begin
        #2;
        preg_req = 1'b1;
        rst_clk  = 1'b0;
        #1;
        checkValue("async_rst_vld", 8'(preg_grant_vld), 8'd0);
        checkValue("async_rst_stall", 8'(preg_stall), 8'd0);
        checkValue("async_rst_cnt", 8'(free_cnt), 8'd32);
        @(posedge clk);
        #1;
        driveInputs(0, 0, 0, 0, 0, 0, 0);
        rst_clk = 1'b1;
      end
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
